// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding,
// default bus widths and the hold counter width.
package bus_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 64;
    localparam int HOLD_CNT_W = 8;

    localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_SAT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_M0   = 2'b01,
        ST_M1   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/bus_arb_mux.sv
// Combinational command mux from the granted master onto the BUS master
// port, plus read-data return gated so only the owner sees m_din.
module bus_arb_mux
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  arb_state_e        state,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    output logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m1_din
);

    // Route the owner's command to BUS and its read data back; idle drives zeros.
    always_comb begin
        m_req  = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_dout = '0;
        m0_din = '0;
        m1_din = '0;
        case (state)
            ST_M0: begin
                m_req  = m0_req;
                m_wr   = m0_wr;
                m_addr = m0_addr;
                m_dout = m0_dout;
                m0_din = m_din;
            end
            ST_M1: begin
                m_req  = m1_req;
                m_wr   = m1_wr;
                m_addr = m1_addr;
                m_dout = m1_dout;
                m1_din = m_din;
            end
            default: begin
                m_req  = 1'b0;
                m_wr   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the single-master BUS block.
// Registered grant FSM (IDLE/M0/M1) with an optional hold limit (HOLD_MAX,
// 0 = unlimited) that forces a handover when the other master is waiting.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN -- when defined, ties in
// IDLE go to the master that was not granted last (m0 first after reset);
// otherwise m0 always wins ties.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int unsigned HOLD_MAX = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    output logic              m0_grant,
    output logic [DATA_W-1:0] m0_din,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m1_din,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    localparam bit HOLD_EN = (HOLD_MAX != 0);
    // Count value on the last permitted cycle before a forced handover.
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST =
        HOLD_EN ? HOLD_CNT_W'(HOLD_MAX - 1) : '0;

    arb_state_e              state_q, state_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                    tie_to_m0_s;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Tie goes to the master that did not hold the bus most recently.
    always_comb begin
        tie_to_m0_s = last_grant_q;
    end

    // Remember which master was granted on each entry into M0/M1.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_d != state_q && state_d == ST_M0) begin
            last_grant_d = 1'b0;
        end else if (state_d != state_q && state_d == ST_M1) begin
            last_grant_d = 1'b1;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin history register; reset to 1 so the first tie goes to m0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: m0 wins every tie.
    always_comb begin
        tie_to_m0_s = 1'b1;
    end
`endif

    // Next-state decision: arbitration from IDLE, release/forced handover otherwise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = tie_to_m0_s ? ST_M0 : ST_M1;
                end else if (m0_req) begin
                    state_d = ST_M0;
                end else if (m1_req) begin
                    state_d = ST_M1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_M0: begin
                if (!m0_req) begin
                    state_d = m1_req ? ST_M1 : ST_IDLE;
                end else if (HOLD_EN && hold_cnt_q == HOLD_LAST && m1_req) begin
                    state_d = ST_M1;
                end else begin
                    state_d = ST_M0;
                end
            end
            ST_M1: begin
                if (!m1_req) begin
                    state_d = m0_req ? ST_M0 : ST_IDLE;
                end else if (HOLD_EN && hold_cnt_q == HOLD_LAST && m0_req) begin
                    state_d = ST_M0;
                end else begin
                    state_d = ST_M1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold counter: cleared on any state change or in IDLE, else saturating increment.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d != state_q || state_d == ST_IDLE) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_CNT_SAT) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Grant state and hold counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign m0_grant = (state_q == ST_M0);
    assign m1_grant = (state_q == ST_M1);

    bus_arb_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .state   (state_q),
        .m0_req  (m0_req),
        .m0_wr   (m0_wr),
        .m0_addr (m0_addr),
        .m0_dout (m0_dout),
        .m1_req  (m1_req),
        .m1_wr   (m1_wr),
        .m1_addr (m1_addr),
        .m1_dout (m1_dout),
        .m_din   (m_din),
        .m_req   (m_req),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_dout  (m_dout),
        .m0_din  (m0_din),
        .m1_din  (m1_din)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: instance A with unlimited hold, instance B with
// HOLD_MAX=4, sharing all inputs. Expected grants are queued when each
// stimulus step is driven and popped after the following clock edge.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [63:0] m0_dout, m1_dout, m_din;

    logic        a_m0_grant, a_m1_grant, a_m_req, a_m_wr;
    logic [63:0] a_m0_din, a_m1_din, a_m_dout;
    logic [15:0] a_m_addr;
    logic        b_m0_grant, b_m1_grant, b_m_req, b_m_wr;
    logic [63:0] b_m0_din, b_m1_din, b_m_dout;
    logic [15:0] b_m_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam logic [1:0] TIE2 = 2'b10;
`else
    localparam logic [1:0] TIE2 = 2'b01;
`endif

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(16), .DATA_W(64), .HOLD_MAX(0)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_grant(a_m0_grant), .m0_din(a_m0_din),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_grant(a_m1_grant), .m1_din(a_m1_din),
        .m_req(a_m_req), .m_wr(a_m_wr), .m_addr(a_m_addr), .m_dout(a_m_dout),
        .m_din(m_din)
    );

    bus_arbiter #(.ADDR_W(16), .DATA_W(64), .HOLD_MAX(4)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_grant(b_m0_grant), .m0_din(b_m0_din),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_grant(b_m1_grant), .m1_din(b_m1_din),
        .m_req(b_m_req), .m_wr(b_m_wr), .m_addr(b_m_addr), .m_dout(b_m_dout),
        .m_din(m_din)
    );

    // Single comparison point: counts and reports mismatches.
    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive requests, queue expected {A grants, B grants} as {m1,m0}, compare after the edge.
    task automatic step(input logic r0, input logic r1,
                        input logic [1:0] ea, input logic [1:0] eb, input string tag);
        logic [3:0] e;
        m0_req = r0;
        m1_req = r1;
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_eq({tag, "_a"}, {62'd0, a_m1_grant, a_m0_grant}, {62'd0, e[3:2]});
        chk_eq({tag, "_b"}, {62'd0, b_m1_grant, b_m0_grant}, {62'd0, e[1:0]});
    endtask

    // Every A-side output must be zero.
    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_grants"}, {62'd0, a_m1_grant, a_m0_grant}, 64'd0);
        chk_eq({tag, "_mreq_wr"}, {62'd0, a_m_req, a_m_wr}, 64'd0);
        chk_eq({tag, "_maddr"}, {48'd0, a_m_addr}, 64'd0);
        chk_eq({tag, "_mdout"}, a_m_dout, 64'd0);
        chk_eq({tag, "_m0din"}, a_m0_din, 64'd0);
        chk_eq({tag, "_m1din"}, a_m1_din, 64'd0);
    endtask

    initial begin
        reset   = 1'b1;
        m0_req  = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0000; m0_dout = 64'h0;
        m1_req  = 1'b0; m1_wr = 1'b0; m1_addr = 16'h0000; m1_dout = 64'h0;
        m_din   = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 2'b00, 2'b00, "idle_after_reset");

        // Ties from idle with one-cycle gaps: first to m0, then per arbitration mode.
        step(1'b1, 1'b1, 2'b01, 2'b01, "tie1");
        step(1'b0, 1'b0, 2'b00, 2'b00, "gap1");
        step(1'b1, 1'b1, TIE2,  TIE2,  "tie2");
        step(1'b0, 1'b0, 2'b00, 2'b00, "gap2");
        step(1'b1, 1'b1, 2'b01, 2'b01, "tie3");
        step(1'b0, 1'b0, 2'b00, 2'b00, "gap3");

        // Single master write forwarded to the bus.
        m0_addr = 16'h0010; m0_wr = 1'b1; m0_dout = 64'hA5;
        m1_addr = 16'h7777; m1_wr = 1'b0; m1_dout = 64'h5A5A;
        m_din   = 64'h1234_5678;
        step(1'b1, 1'b0, 2'b01, 2'b01, "m0_only");
        chk_eq("m_addr", {48'd0, a_m_addr}, 64'h0010);
        chk_eq("m_wr_req", {62'd0, a_m_req, a_m_wr}, 64'd3);
        chk_eq("m_dout", a_m_dout, 64'hA5);
        chk_eq("m0_din", a_m0_din, 64'h1234_5678);
        chk_eq("m1_din_zero", a_m1_din, 64'd0);
        // Request dropped in grant cycle: grant held, BUS sees no request.
        m0_req = 1'b0;
        #1;
        chk_eq("drop_grant_held", {63'd0, a_m0_grant}, 64'd1);
        chk_eq("drop_mreq", {63'd0, a_m_req}, 64'd0);
        step(1'b0, 1'b0, 2'b00, 2'b00, "drop_release");

        // Direct handover M0 -> M1 with no idle bubble.
        step(1'b1, 1'b0, 2'b01, 2'b01, "ho_m0");
        step(1'b1, 1'b1, 2'b01, 2'b01, "ho_m0_hold");
        step(1'b0, 1'b1, 2'b10, 2'b10, "ho_m1");
        chk_eq("ho_m_addr", {48'd0, a_m_addr}, 64'h7777);
        m_din = 64'hDEAD_BEEF;
        #1;
        chk_eq("rd_m1_din", a_m1_din, 64'hDEAD_BEEF);
        chk_eq("rd_m0_din", a_m0_din, 64'd0);

        // Asynchronous reset while M1 owns the bus.
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        m1_req = 1'b0;
        m_din = 64'h0;
        step(1'b0, 1'b0, 2'b00, 2'b00, "post_reset_idle");

        // Hold limit: B forces handover after 4 cycles each way; A never does.
        step(1'b1, 1'b0, 2'b01, 2'b01, "hold_g1");
        step(1'b1, 1'b1, 2'b01, 2'b01, "hold_g2");
        step(1'b1, 1'b1, 2'b01, 2'b01, "hold_g3");
        step(1'b1, 1'b1, 2'b01, 2'b01, "hold_g4");
        step(1'b1, 1'b1, 2'b01, 2'b10, "hold_force_m1");
        step(1'b1, 1'b1, 2'b01, 2'b10, "hold_m1_2");
        step(1'b1, 1'b1, 2'b01, 2'b10, "hold_m1_3");
        step(1'b1, 1'b1, 2'b01, 2'b10, "hold_m1_4");
        step(1'b1, 1'b1, 2'b01, 2'b01, "hold_force_m0");
        step(1'b0, 1'b0, 2'b00, 2'b00, "hold_release");

        chk_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
